// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and display constants for the lock sequencer.
package lock_pkg;
    typedef enum logic [1:0] {ENTRY, UNLOCKED, LOCKOUT} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [3:0] ANODE_RST = 4'b1110;
endpackage

// File: rtl/seg_scan.sv
// seg_scan: rotates the active-low anodes every SCAN_DIV cycles and latches the glyph of the newly selected digit.
// i_glyph carries the glyphs valid after the coming edge, so anode and segment always update together.
module seg_scan
    import lock_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0][6:0] i_glyph,
    output logic [3:0]      o_anode,
    output logic [6:0]      o_seg
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    logic [DW-1:0] r_div;
    logic [1:0]    r_sel;
    logic          w_tc;
    logic [1:0]    w_sel_nxt;
    assign w_tc      = r_div == DW'(SCAN_DIV - 1);
    assign w_sel_nxt = w_tc ? r_sel + 2'd1 : r_sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_sel   <= '0;
            o_anode <= ANODE_RST;
            o_seg   <= SEG_BLANK;
        end else begin
            r_div   <= w_tc ? '0 : r_div + 1'b1;
            r_sel   <= w_sel_nxt;
            o_anode <= ~(4'b0001 << w_sel_nxt);
            o_seg   <= i_glyph[w_sel_nxt];
        end
    end
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: code-entry FSM with failed-attempt lockout, timed auto-relock and display glyph selection.
// Define LOCK_EARLY_FAIL_EN to end an attempt on its first mismatching digit.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 50_000_000,
    parameter int UNLOCK_CYC  = 100_000_000,
    parameter int SCAN_DIV    = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            btn_pulse,
    input  logic [2*CODE_LEN-1:0] code,
    input  logic                  relock,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic [1:0]            fail_cnt,
    output logic [3:0]            anode_active,
    output logic [6:0]            segment
);
    localparam int TW = $clog2((LOCKOUT_CYC > UNLOCK_CYC ? LOCKOUT_CYC : UNLOCK_CYC) + 1);
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic            r_mis, w_mis_nxt;
    logic [1:0]      w_fail_nxt;
    logic [TW-1:0]   r_tmr, w_tmr_nxt;
    logic [1:0]      w_val, w_dig;
    logic            w_multi, w_bad, w_mis, w_last, w_done, w_unl_nxt, w_lo_nxt;
    logic [3:0][6:0] w_glyph;
    assign w_val   = btn_pulse[3] ? 2'd3 : btn_pulse[2] ? 2'd2 : btn_pulse[1] ? 2'd1 : 2'd0;
    assign w_multi = (btn_pulse & (btn_pulse - 4'd1)) != 4'd0;
    assign w_dig   = code[{r_idx, 1'b0} +: 2];
    assign w_bad   = w_multi | (w_val != w_dig);
    assign w_mis   = r_mis | w_bad;
    assign w_last  = r_idx == 3'(CODE_LEN - 1);
`ifdef LOCK_EARLY_FAIL_EN
    assign w_done  = w_last | w_bad;
`else
    assign w_done  = w_last;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ENTRY;
            r_idx      <= '0;
            r_mis      <= 1'b0;
            r_tmr      <= '0;
            fail_cnt   <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_mis      <= w_mis_nxt;
            r_tmr      <= w_tmr_nxt;
            fail_cnt   <= w_fail_nxt;
            unlocked   <= w_unl_nxt;
            locked_out <= w_lo_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mis_nxt   = r_mis;
        w_fail_nxt  = fail_cnt;
        case (r_state)
            ENTRY: begin
                if (relock) begin
                    w_idx_nxt = '0;
                    w_mis_nxt = 1'b0;
                end else if (btn_pulse != 4'd0) begin
                    w_idx_nxt = w_done ? 3'd0 : r_idx + 3'd1;
                    w_mis_nxt = w_done ? 1'b0 : w_mis;
                    if (w_done && !w_mis) begin
                        w_state_nxt = UNLOCKED;
                        w_fail_nxt  = '0;
                    end else if (w_done && int'(fail_cnt) + 1 < MAX_TRIES) begin
                        w_fail_nxt  = fail_cnt + 2'd1;
                    end else if (w_done) begin
                        w_state_nxt = LOCKOUT;
                        w_fail_nxt  = 2'(MAX_TRIES);
                    end
                end
            end
            UNLOCKED: if (relock || r_tmr == TW'(UNLOCK_CYC - 1)) w_state_nxt = ENTRY;
            LOCKOUT: begin
                if (r_tmr == TW'(LOCKOUT_CYC - 1)) begin
                    w_state_nxt = ENTRY;
                    w_fail_nxt  = '0;
                end
            end
            default: w_state_nxt = ENTRY;
        endcase
        // timer restarts whenever a timed state is entered
        w_tmr_nxt = (w_state_nxt == r_state && r_state != ENTRY) ? r_tmr + 1'b1 : '0;
    end
    always_comb begin
        w_unl_nxt = w_state_nxt == UNLOCKED;
        w_lo_nxt  = w_state_nxt == LOCKOUT;
        for (int d = 0; d < 4; d++)
            w_glyph[d] = w_unl_nxt ? SEG_U : w_lo_nxt ? SEG_L : (3'(d) < w_idx_nxt ? SEG_DASH : SEG_BLANK);
    end
    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .i_glyph (w_glyph),
        .o_anode (anode_active),
        .o_seg   (segment)
    );
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed stimulus with a queue-based model of attempts, countdown timers and scan position.
module tb_lock_sequencer;
    logic       clk = 1'b0, rst = 1'b1, relock = 1'b0;
    logic [3:0] btn_pulse = 4'd0;
    logic [7:0] code = 8'b00_01_10_11;
    logic       unlocked, locked_out;
    logic [1:0] fail_cnt;
    logic [3:0] anode_active;
    logic [6:0] segment;
    int n_tests = 0, n_fail = 0;
`ifdef LOCK_EARLY_FAIL_EN
    localparam bit EARLY = 1'b1;
    localparam int N_WRONG = 1;
`else
    localparam bit EARLY = 1'b0;
    localparam int N_WRONG = 4;
`endif
    lock_sequencer #(.LOCKOUT_CYC(20), .UNLOCK_CYC(30), .SCAN_DIV(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pulse    (btn_pulse),
        .code         (code),
        .relock       (relock),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .fail_cnt     (fail_cnt),
        .anode_active (anode_active),
        .segment      (segment)
    );
    always #5 clk = ~clk;
    // model: mode 0 entry, 1 open, 2 lockout; m_ok holds per-digit match results of the attempt in progress
    int m_mode, m_fail, m_left, m_cyc;
    bit m_valid = 1'b0;
    bit m_ok[$];
    always @(posedge clk) begin : model
        bit ok, all_ok;
        logic [7:0] cv;
        if (rst) begin
            m_mode = 0; m_fail = 0; m_left = 0; m_cyc = 0; m_valid = 1'b1;
            m_ok.delete();
        end else begin
            m_cyc++;
            if (m_mode == 0) begin
                if (relock) m_ok.delete();
                else if (btn_pulse != 4'd0) begin
                    cv = code;
                    ok = btn_pulse == (4'b0001 << cv[2*m_ok.size() +: 2]);
                    m_ok.push_back(ok);
                    if (m_ok.size() == 4 || (EARLY && !ok)) begin
                        all_ok = 1'b1;
                        foreach (m_ok[i]) all_ok &= m_ok[i];
                        if (all_ok) begin m_mode = 1; m_left = 30; m_fail = 0; end
                        else if (m_fail + 1 >= 3) begin m_mode = 2; m_left = 20; m_fail = 3; end
                        else m_fail++;
                        m_ok.delete();
                    end
                end
            end else if (m_mode == 1) begin
                if (relock || m_left == 1) m_mode = 0;
                else m_left--;
            end else begin
                if (m_left == 1) begin m_mode = 0; m_fail = 0; end
                else m_left--;
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (m_valid) begin : cmp
        int sel;
        logic [6:0] es;
        sel = (m_cyc / 2) % 4;
        es = m_mode == 1 ? 7'b1000001 : m_mode == 2 ? 7'b1110001 : (sel < m_ok.size() ? 7'b1111110 : 7'b1111111);
        chk("model_unlocked", 32'(unlocked), 32'(m_mode == 1));
        chk("model_locked_out", 32'(locked_out), 32'(m_mode == 2));
        chk("model_fail_cnt", 32'(fail_cnt), 32'(m_fail));
        chk("model_anode", 32'(anode_active), 32'(4'hf & ~(4'b0001 << sel)));
        chk("model_segment", 32'(segment), 32'(es));
    end
    task automatic step(input logic [3:0] b, input logic r);
        btn_pulse = b;
        relock = r;
        @(negedge clk);
        btn_pulse = 4'd0;
        relock = 1'b0;
    endtask
    task automatic enter_ok();
        step(4'b1000, 1'b0); step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
    endtask
    task automatic attempt_wrong();
        repeat (N_WRONG) step(4'b0001, 1'b0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_anode", 32'(anode_active), 32'h e);
        chk("rst_segment", 32'(segment), 32'h7f);
        chk("rst_unlocked", 32'(unlocked), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
        // correct entry and auto-relock after 30 cycles
        step(4'b1000, 1'b0); step(4'b0100, 1'b0); step(4'b0010, 1'b0);
        chk("pre_unlock", 32'(unlocked), 0);
        step(4'b0001, 1'b0);
        chk("unlock", 32'(unlocked), 1);
        chk("unlock_fail", 32'(fail_cnt), 0);
        for (int i = 0; i < 29; i++) begin
            chk("unlock_seg_u", 32'(segment), 32'h41);
            @(negedge clk);
        end
        chk("unlock_last_cycle", 32'(unlocked), 1);
        @(negedge clk);
        chk("auto_relock", 32'(unlocked), 0);
        // three wrong attempts lead to lockout
        attempt_wrong();
        chk("wrong1", 32'(fail_cnt), 1);
        attempt_wrong();
        chk("wrong2", 32'(fail_cnt), 2);
        attempt_wrong();
        chk("lockout", 32'(locked_out), 1);
        chk("lockout_fail", 32'(fail_cnt), 3);
        chk("lockout_seg_l", 32'(segment), 32'h71);
        step(4'b1000, 1'b0); step(4'b0100, 1'b1); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
        chk("lockout_ignores", 32'(unlocked), 0);
        repeat (15) @(negedge clk);
        chk("lockout_last_cycle", 32'(locked_out), 1);
        @(negedge clk);
        chk("lockout_end", 32'(locked_out), 0);
        chk("lockout_end_fail", 32'(fail_cnt), 0);
        // multi-hot first digit
`ifdef LOCK_EARLY_FAIL_EN
        step(4'b1100, 1'b0);
`else
        step(4'b1100, 1'b0); step(4'b0100, 1'b0); step(4'b0010, 1'b0); step(4'b0001, 1'b0);
`endif
        chk("multihot_fail", 32'(fail_cnt), 1);
        chk("multihot_locked", 32'(unlocked), 0);
        // partial entry discarded by relock, including a same-edge pulse
        step(4'b1000, 1'b0); step(4'b0100, 1'b0);
        step(4'b1000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("relock_blank", 32'(segment), 32'h7f);
            @(negedge clk);
        end
        chk("relock_keeps_fail", 32'(fail_cnt), 1);
        enter_ok();
        chk("after_relock_unlock", 32'(unlocked), 1);
        chk("after_relock_fail", 32'(fail_cnt), 0);
        step(4'b0000, 1'b1);
        chk("relock_close", 32'(unlocked), 0);
        // early-fail behaviour
        step(4'b0001, 1'b0);
`ifdef LOCK_EARLY_FAIL_EN
        chk("early_fail_first", 32'(fail_cnt), 1);
`else
        chk("no_early_fail_1", 32'(fail_cnt), 0);
        step(4'b0001, 1'b0); step(4'b0001, 1'b0);
        chk("no_early_fail_3", 32'(fail_cnt), 0);
        step(4'b0001, 1'b0);
        chk("verdict_at_4", 32'(fail_cnt), 1);
`endif
        // code change mid-entry applies to later digits
        step(4'b1000, 1'b0); step(4'b0100, 1'b0);
        code = 8'b01_10_10_11;
        step(4'b0100, 1'b0); step(4'b0010, 1'b0);
        chk("code_change_unlock", 32'(unlocked), 1);
        code = 8'b00_01_10_11;
        // reset mid-unlock
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_unlocked", 32'(unlocked), 0);
        chk("rst_mid_anode", 32'(anode_active), 32'h e);
        chk("rst_mid_segment", 32'(segment), 32'h7f);
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
